stb_pacer: RTL and testbench



---
 rtl/stb_pacer_pkg.sv | 5 +
 rtl/stb_pacer.sv | 90 +++++++++
 tb/tb_stb_pacer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stb_pacer_pkg.sv
// Shared defaults for the strobe pacing stage.
package stb_pacer_pkg;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_MIN_GAP = 16;
endpackage

// File: rtl/stb_pacer.sv
// Counts bursty event pulses and re-emits them as single-cycle strobes spaced
// exactly MIN_GAP cycles apart while events remain pending.
module stb_pacer
  import stb_pacer_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned MIN_GAP = DEF_MIN_GAP
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             evt_stb,
  input  logic             en,
  input  logic             ovf_clr,
  output logic             out_stb,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             ovf
);

  localparam int unsigned      GAP_W    = 16;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, STB, GAP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_pending;
  logic             r_out_stb;
  logic             r_ovf;
  logic             w_inc;
  logic             w_dec;
  logic             w_drop;
  logic             w_have;

  assign w_have = (r_pending != '0) && en;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_have) w_next = STB;
      STB:     w_next = GAP;
      GAP:     if (r_gap_cnt == '0) w_next = w_have ? STB : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // STB always moves to GAP, so entering STB is the only decrement point.
  assign w_dec  = (w_next == STB);
  assign w_inc  = evt_stb;
  assign w_drop = w_inc && !w_dec && (r_pending == CNT_MAX);

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_out_stb <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_out_stb <= (w_next == STB);
      if (r_state == STB)
        r_gap_cnt <= GAP_LOAD;
      else if (r_state == GAP && r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
    end
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_inc && !w_dec && r_pending != CNT_MAX)
        r_pending <= r_pending + CNT_W'(1);
      else if (w_dec && !w_inc)
        r_pending <= r_pending - CNT_W'(1);
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign out_stb = r_out_stb;
  assign pending = r_pending;
  assign ovf     = r_ovf;
  assign busy    = (r_state != IDLE) || (r_pending != '0);

endmodule

// File: tb/tb_stb_pacer.sv
// Directed bench for stb_pacer: CNT_W=3 with MIN_GAP=4 and MIN_GAP=2 instances
// sharing the same stimulus.
module tb_stb_pacer;

  logic       in_clk = 1'b0;
  logic       rst;
  logic       evt_stb;
  logic       en;
  logic       ovf_clr;
  logic       s4_stb, s4_busy, s4_ovf;
  logic [2:0] s4_pend;
  logic       s2_stb, s2_busy, s2_ovf;
  logic [2:0] s2_pend;

  int errors = 0;
  int checks = 0;

  always #5 in_clk = ~in_clk;

  stb_pacer #(.CNT_W(3), .MIN_GAP(4)) dut4 (
    .in_clk(in_clk), .rst(rst), .evt_stb(evt_stb), .en(en), .ovf_clr(ovf_clr),
    .out_stb(s4_stb), .pending(s4_pend), .busy(s4_busy), .ovf(s4_ovf)
  );

  stb_pacer #(.CNT_W(3), .MIN_GAP(2)) dut2 (
    .in_clk(in_clk), .rst(rst), .evt_stb(evt_stb), .en(en), .ovf_clr(ovf_clr),
    .out_stb(s2_stb), .pending(s2_pend), .busy(s2_busy), .ovf(s2_ovf)
  );

  // Advance to 1 time unit after the next rising edge; that interval is "the cycle".
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; evt_stb = 1'b0; en = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; evt_stb = 1'b0; en = 1'b0; ovf_clr = 1'b0;
    #3;
    checks++;
    if ({s4_stb, s4_pend, s4_busy, s4_ovf} !== 6'b0) begin
      errors++;
      $display("FAIL reset4: stb=%b pend=%0d busy=%b ovf=%b, required all 0", s4_stb, s4_pend, s4_busy, s4_ovf);
    end
    checks++;
    if ({s2_stb, s2_pend, s2_busy, s2_ovf} !== 6'b0) begin
      errors++;
      $display("FAIL reset2: stb=%b pend=%0d busy=%b ovf=%b, required all 0", s2_stb, s2_pend, s2_busy, s2_ovf);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [2:0] exp_pend [0:3];
    logic       exp_busy [0:7];
    exp_pend = '{3'd0, 3'd1, 3'd0, 3'd0};
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    en = 1'b1;
    evt_stb = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (s4_stb !== (c == 2)) begin
        errors++;
        $display("FAIL single_stb c%0d: got %b, required %b", c, s4_stb, (c == 2));
      end
      if (c < 4) begin
        checks++;
        if (s4_pend !== exp_pend[c]) begin
          errors++;
          $display("FAIL single_pend c%0d: got %0d, required %0d", c, s4_pend, exp_pend[c]);
        end
      end
      checks++;
      if (s4_busy !== exp_busy[c]) begin
        errors++;
        $display("FAIL single_busy c%0d: got %b, required %b", c, s4_busy, exp_busy[c]);
      end
      tick();
      evt_stb = 1'b0;
    end
  endtask

  task automatic test_burst();
    int max_pend = 0;
    int nstb = 0;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      evt_stb = (c < 5);
      checks++;
      if (s4_stb !== (c == 2 || c == 6 || c == 10 || c == 14 || c == 18)) begin
        errors++;
        $display("FAIL burst_stb c%0d: got %b", c, s4_stb);
      end
      if (s4_stb === 1'b1) nstb++;
      if (int'(s4_pend) > max_pend) max_pend = int'(s4_pend);
      tick();
    end
    evt_stb = 1'b0;
    checks++;
    if (nstb != 5 || max_pend != 4) begin
      errors++;
      $display("FAIL burst_counts: strobes=%0d maxpend=%0d, required 5 and 4", nstb, max_pend);
    end
    checks++;
    if (s4_ovf !== 1'b0) begin
      errors++;
      $display("FAIL burst_ovf: got %b, required 0", s4_ovf);
    end
  endtask

  task automatic test_overflow();
    int  nstb = 0;
    logic prev = 1'b0;
    do_reset();
    en = 1'b0;
    evt_stb = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    evt_stb = 1'b0;
    checks++;
    if (s4_pend !== 3'd7 || s4_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fill: pend=%0d ovf=%b, required 7 and 1", s4_pend, s4_ovf);
    end
    ovf_clr = 1'b1;
    tick();
    checks++;
    if (s4_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b, required 0", s4_ovf);
    end
    evt_stb = 1'b1;
    tick();
    evt_stb = 1'b0;
    ovf_clr = 1'b0;
    checks++;
    if (s4_ovf !== 1'b1 || s4_pend !== 3'd7) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf=%b pend=%0d, required 1 and 7", s4_ovf, s4_pend);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (s4_stb === 1'b1) nstb++;
      checks++;
      if (prev === 1'b1 && s4_stb === 1'b1) begin
        errors++;
        $display("FAIL ovf_consec c%0d: out_stb high two cycles running", c);
      end
      prev = s4_stb;
    end
    checks++;
    if (nstb != 7 || s4_pend !== 3'd0) begin
      errors++;
      $display("FAIL ovf_drain: strobes=%0d pend=%0d, required 7 and 0", nstb, s4_pend);
    end
  endtask

  task automatic test_simul_full();
    do_reset();
    en = 1'b0;
    evt_stb = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    en = 1'b1;
    tick();
    evt_stb = 1'b0;
    en = 1'b0;
    checks++;
    if (s4_stb !== 1'b1 || s4_pend !== 3'd7 || s4_ovf !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: stb=%b pend=%0d ovf=%b, required 1 7 0", s4_stb, s4_pend, s4_ovf);
    end
  endtask

  task automatic test_en_gate();
    do_reset();
    en = 1'b1;
    evt_stb = 1'b1;
    tick();
    tick();
    tick();
    evt_stb = 1'b0;
    en = 1'b0;
    // Now in cycle 3: first GAP cycle after the strobe in cycle 2.
    for (int c = 3; c < 10; c++) begin
      checks++;
      if (s4_stb !== 1'b0) begin
        errors++;
        $display("FAIL gate_stb c%0d: got %b, required 0", c, s4_stb);
      end
      tick();
    end
    checks++;
    if (s4_pend !== 3'd2 || s4_busy !== 1'b1) begin
      errors++;
      $display("FAIL gate_hold: pend=%0d busy=%b, required 2 and 1", s4_pend, s4_busy);
    end
    en = 1'b1;
    checks++;
    if (s4_stb !== 1'b0) begin
      errors++;
      $display("FAIL gate_rise0: got %b, required 0", s4_stb);
    end
    tick();
    checks++;
    if (s4_stb !== 1'b1 || s4_pend !== 3'd1) begin
      errors++;
      $display("FAIL gate_rise1: stb=%b pend=%0d, required 1 and 1", s4_stb, s4_pend);
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1;
    evt_stb = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    evt_stb = 1'b0;
    checks++;
    if (s4_pend !== 3'd3 || s4_stb !== 1'b0 || s4_busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: pend=%0d stb=%b busy=%b, required 3 0 1", s4_pend, s4_stb, s4_busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s4_stb, s4_pend, s4_busy, s4_ovf} !== 6'b0) begin
      errors++;
      $display("FAIL rmid_async: stb=%b pend=%0d busy=%b ovf=%b, required all 0", s4_stb, s4_pend, s4_busy, s4_ovf);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (s4_stb !== 1'b0 || s4_pend !== 3'd0) begin
        errors++;
        $display("FAIL rmid_quiet c%0d: stb=%b pend=%0d, required 0 0", c, s4_stb, s4_pend);
      end
    end
  endtask

  task automatic test_back_to_back_gap2();
    int nstb = 0;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      evt_stb = (c < 5);
      checks++;
      if (s2_stb !== (c == 2 || c == 4 || c == 6 || c == 8 || c == 10)) begin
        errors++;
        $display("FAIL gap2_stb c%0d: got %b", c, s2_stb);
      end
      if (s2_stb === 1'b1) nstb++;
      tick();
    end
    evt_stb = 1'b0;
    checks++;
    if (nstb != 5 || s2_pend !== 3'd0 || s2_ovf !== 1'b0) begin
      errors++;
      $display("FAIL gap2_end: strobes=%0d pend=%0d ovf=%b, required 5 0 0", nstb, s2_pend, s2_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simul_full();
    test_en_gate();
    test_reset_mid();
    test_back_to_back_gap2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
